bcd_counter: RTL and testbench

BCD_COUNTER -- requirements
Module: bcd_counter

---
 rtl/bcd_counter.sv | 83 ++++++++
 tb/tb_bcd_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter.sv
// bcd_counter: DIGITS-digit decimal up/down counter held purely as 4-bit
// BCD digit registers. Edge priority is clear > load > tick > hold.
// Outputs are registered: bcd, carry (one-cycle wrap pulse) and changed
// (one-cycle pulse when bcd took a new value) all reflect the inputs
// sampled at the previous rising edge of sys_clk.
//
// Strobe semantics: tick, clear and load are level-sampled on every rising
// edge with no handshake and no edge detection; each cycle a strobe is high
// it acts once. There is no back-pressure, the counter always accepts.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  tick,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic                  changed
);

  logic [4*DIGITS-1:0] nxt_bcd;
  logic                nxt_carry;
  logic                ripple;
  logic [3:0]          digit;

  // Next-state for the digit chain: clear, saturating load, or a decimal
  // ripple step. A ripple that runs off the top digit is a full-range wrap.
  always_comb begin
    nxt_bcd   = bcd;
    nxt_carry = 1'b0;
    ripple    = 1'b1;
    digit     = 4'd0;
    if (clear) begin
      nxt_bcd = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = load_value[4*i +: 4];
        nxt_bcd[4*i +: 4] = (digit > 4'd9) ? 4'd9 : digit;
      end
    end else if (tick) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = bcd[4*i +: 4];
        if (ripple) begin
          if (up) begin
            if (digit == 4'd9) begin
              nxt_bcd[4*i +: 4] = 4'd0;
            end else begin
              nxt_bcd[4*i +: 4] = digit + 4'd1;
              ripple = 1'b0;
            end
          end else begin
            if (digit == 4'd0) begin
              nxt_bcd[4*i +: 4] = 4'd9;
            end else begin
              nxt_bcd[4*i +: 4] = digit - 4'd1;
              ripple = 1'b0;
            end
          end
        end
      end
      // Ripple still set after the top digit means every digit wrapped.
      nxt_carry = ripple;
    end
  end

  // Register count and status pulses; reset clears everything immediately.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      bcd     <= '0;
      carry   <= 1'b0;
      changed <= 1'b0;
    end else begin
      bcd     <= nxt_bcd;
      carry   <= nxt_carry;
      changed <= (nxt_bcd != bcd);
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed vectors for a 2-digit bcd_counter. The driver
// pushes the hand-computed response for each cycle into exp_q; a monitor
// pops and compares once per rising edge.
module tb_bcd_counter;

  localparam int DIGITS = 2;
  localparam int BW     = 4 * DIGITS;
  localparam int EW     = BW + 2;

  // ---------------- clock / reset ----------------
  logic          sys_clk = 1'b0;
  logic          sys_reset_n;
  logic          tick, up, clear, load;
  logic [BW-1:0] load_value;
  logic [BW-1:0] bcd;
  logic          carry, changed;

  always #5 sys_clk = ~sys_clk;

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .tick        (tick),
    .up          (up),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .bcd         (bcd),
    .carry       (carry),
    .changed     (changed)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got bcd=%h carry=%b changed=%b, expected bcd=%h carry=%b changed=%b",
               name, got[EW-1:2], got[1], got[0], exp[EW-1:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: every rising edge presents a new registered response.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {bcd, carry, changed}, e);
      end
    end
  end

  // Decimal value 0..99 as two BCD digits.
  function automatic logic [BW-1:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'((n / 10) % 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic rst, input logic c, input logic l, input logic [BW-1:0] lv,
                     input logic t, input logic u,
                     input logic [BW-1:0] eb, input logic ec, input logic ech);
    @(negedge sys_clk);
    sys_reset_n = rst;
    clear       = c;
    load        = l;
    load_value  = lv;
    tick        = t;
    up          = u;
    exp_q.push_back({eb, ec, ech});
  endtask

  task automatic tick_up(input logic [BW-1:0] eb, input logic ec);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, eb, ec, 1'b1);
  endtask

  task automatic tick_dn(input logic [BW-1:0] eb, input logic ec);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, eb, ec, 1'b1);
  endtask

  task automatic hold(input logic [BW-1:0] eb);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, eb, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [BW-1:0] lv, input logic [BW-1:0] eb, input logic ech);
    cyc(1'b1, 1'b0, 1'b1, lv, 1'b0, 1'b1, eb, 1'b0, ech);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    sys_reset_n = 1'b0;
    tick = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
    #1;
    check("reset_state", {bcd, carry, changed}, '0);

    // Inputs ignored while reset is held.
    cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Twelve single ticks up from zero.
    for (int k = 1; k <= 12; k++) begin
      tick_up(to_bcd(k), 1'b0);
      hold(to_bcd(k));
    end

    // Load 98, tick to 99, wrap to 00 with one-cycle carry.
    do_load(8'h98, 8'h98, 1'b1);
    tick_up(8'h99, 1'b0);
    tick_up(8'h00, 1'b1);
    hold(8'h00);

    // Down wrap from 00, then ordinary decrement.
    tick_dn(8'h99, 1'b1);
    tick_dn(8'h98, 1'b0);

    // Priority: clear beats load and tick; load beats tick.
    cyc(1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    do_load(8'h45, 8'h45, 1'b1);
    do_load(8'h45, 8'h45, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1);
    do_load(8'hA3, 8'h93, 1'b1);
    do_load(8'h9F, 8'h99, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Direction changes between consecutive ticks.
    do_load(8'h50, 8'h50, 1'b1);
    tick_up(8'h51, 1'b0);
    tick_dn(8'h50, 1'b0);
    tick_dn(8'h49, 1'b0);
    tick_up(8'h50, 1'b0);
    tick_dn(8'h49, 1'b0);

    // Tick held high 25 cycles from 90: single carry at 99 -> 00.
    do_load(8'h90, 8'h90, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      tick_up(to_bcd((90 + k) % 100), (k == 10));
    end
    hold(8'h15);

    // Asynchronous reset mid-cycle while holding 37.
    do_load(8'h37, 8'h37, 1'b1);
    hold(8'h37);
    @(posedge sys_clk);
    #4;
    sys_reset_n = 1'b0;
    #1;
    check("async_reset", {bcd, carry, changed}, '0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
    tick_up(8'h02, 1'b0);
    hold(8'h02);

    // Let the monitor consume the last entries.
    repeat (2) @(negedge sys_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
